// File: rtl/note_tone_gen.sv
// Phase-accumulator tone generator with an attack/sustain/release envelope.
// Optional TONE_TRIANGLE_EN selects a triangle waveform instead of a square.
module note_tone_gen #(
  parameter int ACC_W    = 32,
  parameter int ATK_STEP = 4,
  parameter int REL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] freq,
  input  logic             gate,
  input  logic             sample_req,
  output logic [15:0]      sample,
  output logic             sample_valid,
  output logic             active,
  output logic [7:0]       env_level
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [7:0]       env;
  logic [7:0]       env_nxt;
  logic [8:0]       env_up;
  logic [7:0]       env_dn;
  logic             note_on;
  logic [15:0]      wave;

  assign note_on = gate && (freq != '0);
  assign env_up  = {1'b0, env} + 9'(ATK_STEP);
  assign env_dn  = (env > 8'(REL_STEP)) ? env - 8'(REL_STEP) : 8'd0;

  always_comb begin
    env_nxt = env;
    if (state == IDLE) begin
      env_nxt = 8'd0;
    end else if (sample_req) begin
      if (state == ATTACK) begin
        env_nxt = (env_up > 9'd255) ? 8'hff : env_up[7:0];
      end else if (state == RELEASE) begin
        env_nxt = env_dn;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (note_on) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (!note_on) state_nxt = RELEASE;
        else if (env_nxt == 8'hff) state_nxt = SUSTAIN;
      end
      SUSTAIN: begin
        if (!note_on) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (note_on) state_nxt = ATTACK;
        else if (env_nxt == 8'd0) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    if (state != IDLE && sample_req) acc_nxt = acc + freq;
    if (state == RELEASE && state_nxt == IDLE) acc_nxt = '0;
  end

  // Sample is built from the post-update phase and envelope.
`ifdef TONE_TRIANGLE_EN
  logic [7:0]        tri_u;
  logic signed [8:0] tri_s;

  always_comb begin
    tri_u = acc_nxt[ACC_W-1] ? ~acc_nxt[ACC_W-2 -: 8]
                             : acc_nxt[ACC_W-2 -: 8];
    tri_s = $signed({1'b0, tri_u}) - 9'sd128;
    wave  = 16'(tri_s) * {8'd0, env_nxt};
  end
`else
  logic [15:0] mag;

  always_comb begin
    mag  = {1'b0, env_nxt, 7'd0};
    wave = acc_nxt[ACC_W-1] ? -mag : mag;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      env          <= 8'd0;
      sample       <= 16'd0;
      sample_valid <= 1'b0;
    end else begin
      acc          <= acc_nxt;
      env          <= env_nxt;
      sample_valid <= sample_req;
      if (sample_req) sample <= wave;
    end
  end

  assign env_level = env;

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Sits directly downstream of the note datapath and upstream of the audio codec interface.
- Converts the datapath's 32-bit frequency word into signed 16-bit PCM samples, one per codec sample request.
- Uses a phase accumulator for the tone and an attack/sustain/release amplitude envelope so that notes start and stop without clicks.

Parameters:
- ACC_W, 32, phase accumulator and freq width; the oscillator MSB is acc[ACC_W-1].
- ATK_STEP, 4, envelope increment per sample_req in ATTACK (8-bit, saturates at 255).
- REL_STEP, 1, envelope decrement per sample_req in RELEASE (8-bit, saturates at 0).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- freq  in  ACC_W  phase increment added per sample_req; 0 means silence.
- gate  in  1  level signal, note held; driven by the datapath play state.
- sample_req  in  1  single-cycle pulse from the codec interface, one per LR frame.
- sample  out  16  signed PCM sample, two's complement.
- sample_valid  out  1  single-cycle pulse; sample is updated in the same cycle.
- active  out  1  high when state != IDLE.
- env_level  out  8  current envelope amplitude, for display/debug.

Behaviour:
- Reset (async, reset=0): state=IDLE, acc=0, env=0, sample=0, sample_valid=0, active=0, env_level=0. This holds from any state, including mid-ATTACK or mid-RELEASE. No sample_valid pulse is emitted on reset release.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE. Transitions are evaluated every clk.
- note_on = gate && (freq != 0).
- IDLE -> ATTACK when note_on. acc and env stay 0 while in IDLE.
- ATTACK:
  - On each sample_req: env = min(env+ATK_STEP, 255).
  - -> SUSTAIN in the cycle env reaches 255.
  - -> RELEASE if !note_on. Release takes priority over the SUSTAIN transition in the same cycle.
- SUSTAIN: env held at 255; -> RELEASE if !note_on.
- RELEASE:
  - On each sample_req: env = max(env-REL_STEP, 0).
  - -> IDLE and acc cleared in the cycle env reaches 0.
  - -> ATTACK if note_on returns. env continues from its current value and is not reset; this re-gate takes priority over the IDLE transition.
- Accumulator: on sample_req with state != IDLE, acc <= acc + freq, modulo 2^ACC_W (wraps silently).
  - A freq change mid-note applies at the next sample_req. Phase is continuous: acc is not reset.
- Sample timing: sample_req at cycle N -> sample and sample_valid at N+1. The value is computed from the updated acc and env (post-increment values).
- Square waveform: sample = acc[ACC_W-1] ? -(env<<7) : +(env<<7). Peak magnitude is 32640, so there is no overflow.
- sample_req in IDLE: sample_valid still pulses and sample=0. The codec always receives a sample each frame.
- sample_req more often than once per 2 clk: each pulse is processed independently, with no loss.
- env_level mirrors env. active is registered with the state.

Optional Feature:
- Macro: TONE_TRIANGLE_EN.
- Defined: triangle waveform.
  - t = acc[ACC_W-1] ? ~acc[ACC_W-2:ACC_W-9] : acc[ACC_W-2:ACC_W-9], 8-bit unsigned.
  - sample = (t - 128) * env as a signed product, range -32640..32385.
  - Latency, envelope and FSM are unchanged.
- Undefined: square waveform only, and no multiplier is inferred.

Test Plan:
- Reset: hold reset=0 with gate=1, freq=0x01000000 and sample_req pulsing -> sample=0, sample_valid=0, active=0, env_level=0 throughout.
- Attack:
  - Release reset; gate=1, freq=0x01000000; issue one sample_req -> next cycle sample_valid=1, sample=+512 (env=4, acc=0x01000000), active=1.
  - After 64 sample_reqs -> env_level=255, state SUSTAIN.
- Square wrap (no macro): in SUSTAIN, count sample_reqs from note start -> sample=+32640 for reqs 1..127, -32640 for reqs 128..255, +32640 again at req 256 (acc wraps to 0).
- Release: from SUSTAIN, drop gate -> env decrements by 1 per sample_req. After 255 reqs: env_level=0, active=0, acc=0, and subsequent samples are 0.
- Re-gate mid-release: raise gate when env_level=100 -> ATTACK resumes from 100, and SUSTAIN is reached after 39 sample_reqs (100+4*39 saturates to 255).
- Silence and reset mid-operation:
  - gate=1, freq=0 -> stays IDLE.
  - In ATTACK with env=40, set freq=0 -> RELEASE.
  - Assert reset mid-RELEASE -> all outputs return to 0 in the same cycle (asynchronous).
